// File: rtl/gte_seq_pkg.sv
// Shared types for the GTE COP2 sequencer.
//   E_COP2OP     : CPU coprocessor operation codes (5-7 reserved)
//   seqState_t   : sequencer FSM states
//   CTRL_REG_BIT : bit of the engine register ID that selects control registers
package gte_seq_pkg;

    typedef enum logic [2:0] {
        OP_MTC2 = 3'd0,
        OP_CTC2 = 3'd1,
        OP_MFC2 = 3'd2,
        OP_CFC2 = 3'd3,
        OP_CMD  = 3'd4
    } E_COP2OP;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_ISSUE = 3'd3,
        S_BUSY  = 3'd4
    } seqState_t;

    localparam int CTRL_REG_BIT = 5;

    // Control-register ops (CTC2/CFC2) address the upper half of the engine register map.
    function automatic logic isCtrlOp(input logic [2:0] op);
        return (op == OP_CTC2) || (op == OP_CFC2);
    endfunction

endpackage

// File: rtl/gte_cop2_sequencer.sv
// Front-end controller between the CPU COP2 port and the GTE engine.
// Turns MTC2/CTC2 into engine register writes, MFC2/CFC2 into engine register
// reads, and COP2 commands into launch pulses. Register access is held off while
// a command executes; one command may be queued behind the running one; a
// watchdog flags an engine that stays busy too long.
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_cpuValid/o_cpuReady           CPU operation handshake
//   i_cpuOp/i_cpuRegIdx/i_cpuData/i_cpuInstr  operation fields
//   o_cpuRdData/o_cpuRdValid        read result, one-cycle pulse
//   o_gteRegID/o_gteWritReg/o_gteDataOut/i_gteDataIn  engine register port
//   o_gteInstr/o_gteRun/i_gteExecuting                engine command port
//   o_busy                          sequencer not idle or command queued
//   o_wdogErr                       sticky watchdog error
module gte_cop2_sequencer
    import gte_seq_pkg::*;
#(
    parameter int WDOG_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpuValid,
    output logic        o_cpuReady,
    input  logic [2:0]  i_cpuOp,
    input  logic [4:0]  i_cpuRegIdx,
    input  logic [31:0] i_cpuData,
    input  logic [24:0] i_cpuInstr,
    output logic [31:0] o_cpuRdData,
    output logic        o_cpuRdValid,
    output logic [5:0]  o_gteRegID,
    output logic        o_gteWritReg,
    output logic [31:0] o_gteDataOut,
    input  logic [31:0] i_gteDataIn,
    output logic [24:0] o_gteInstr,
    output logic        o_gteRun,
    input  logic        i_gteExecuting,
    output logic        o_busy,
    output logic        o_wdogErr
);

    localparam logic [7:0] WDOG_LIMIT = 8'(WDOG_CYCLES);

    seqState_t   state, stateNxt;
    logic        pendValid, pendValidNxt;
    logic [24:0] pendInstr, pendInstrNxt;
    logic [7:0]  wdogCnt, wdogCntNxt;
    logic        wdogErrNxt;
    logic [5:0]  regIdNxt;
    logic [31:0] dataOutNxt, rdDataNxt;
    logic        writRegNxt, rdValidNxt, runNxt;
    logic [24:0] instrNxt;
    logic        accept;

    // Ready depends on which op is presented while BUSY (only a CMD may queue),
    // so it is decoded from the registered state and the incoming op field.
    assign o_cpuReady = (state == S_IDLE) ||
                        ((state == S_BUSY) && (i_cpuOp == OP_CMD) && !pendValid);
    assign accept     = i_cpuValid && o_cpuReady;
    assign o_busy     = (state != S_IDLE) || pendValid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            pendValid    <= 1'b0;
            pendInstr    <= '0;
            wdogCnt      <= '0;
            o_wdogErr    <= 1'b0;
            o_gteRegID   <= '0;
            o_gteDataOut <= '0;
            o_gteWritReg <= 1'b0;
            o_cpuRdData  <= '0;
            o_cpuRdValid <= 1'b0;
            o_gteInstr   <= '0;
            o_gteRun     <= 1'b0;
        end else begin
            state        <= stateNxt;
            pendValid    <= pendValidNxt;
            pendInstr    <= pendInstrNxt;
            wdogCnt      <= wdogCntNxt;
            o_wdogErr    <= wdogErrNxt;
            o_gteRegID   <= regIdNxt;
            o_gteDataOut <= dataOutNxt;
            o_gteWritReg <= writRegNxt;
            o_cpuRdData  <= rdDataNxt;
            o_cpuRdValid <= rdValidNxt;
            o_gteInstr   <= instrNxt;
            o_gteRun     <= runNxt;
        end
    end

    always_comb begin
        stateNxt     = state;
        pendValidNxt = pendValid;
        pendInstrNxt = pendInstr;
        wdogCntNxt   = wdogCnt;
        wdogErrNxt   = o_wdogErr;
        regIdNxt     = o_gteRegID;
        dataOutNxt   = o_gteDataOut;
        writRegNxt   = 1'b0;
        rdDataNxt    = o_cpuRdData;
        rdValidNxt   = 1'b0;
        instrNxt     = o_gteInstr;
        runNxt       = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (i_cpuOp)
                        OP_MTC2, OP_CTC2: begin
                            regIdNxt               = {1'b0, i_cpuRegIdx};
                            regIdNxt[CTRL_REG_BIT] = isCtrlOp(i_cpuOp);
                            dataOutNxt             = i_cpuData;
                            writRegNxt             = 1'b1;
                            stateNxt               = S_WRITE;
                        end
                        OP_MFC2, OP_CFC2: begin
                            regIdNxt               = {1'b0, i_cpuRegIdx};
                            regIdNxt[CTRL_REG_BIT] = isCtrlOp(i_cpuOp);
                            stateNxt               = S_READ;
                        end
                        OP_CMD: begin
                            instrNxt = i_cpuInstr;
                            runNxt   = 1'b1;
                            stateNxt = S_ISSUE;
                        end
                        default: ;  // reserved op: consumed and dropped
                    endcase
                end
            end
            S_WRITE: stateNxt = S_IDLE;
            S_READ: begin
                // Engine read data is combinational from o_gteRegID, stable this cycle.
                rdDataNxt  = i_gteDataIn;
                rdValidNxt = 1'b1;
                stateNxt   = S_IDLE;
            end
            S_ISSUE: begin
                wdogCntNxt = '0;
                stateNxt   = S_BUSY;
            end
            S_BUSY: begin
                wdogCntNxt = wdogCnt + 8'd1;
                if (wdogCnt + 8'd1 == WDOG_LIMIT) begin
                    // Watchdog has priority over a simultaneous executing drop.
                    wdogErrNxt   = 1'b1;
                    pendValidNxt = 1'b0;
                    stateNxt     = S_IDLE;
                end else if (!i_gteExecuting) begin
                    if (pendValid) begin
                        instrNxt     = pendInstr;
                        runNxt       = 1'b1;
                        pendValidNxt = 1'b0;
                        stateNxt     = S_ISSUE;
                    end else if (accept) begin
                        // CMD arriving in the drop cycle bypasses the pending slot.
                        instrNxt = i_cpuInstr;
                        runNxt   = 1'b1;
                        stateNxt = S_ISSUE;
                    end else begin
                        stateNxt = S_IDLE;
                    end
                end else if (accept) begin
                    pendInstrNxt = i_cpuInstr;
                    pendValidNxt = 1'b1;
                end
            end
            default: stateNxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/gte_cop2_sequencer.md
# gte_cop2_sequencer

Front-end controller between the CPU's COP2 port and the GTE engine. It accepts CPU coprocessor operations (MTC2, CTC2, MFC2, CFC2, COP2 command) over a valid/ready handshake and converts them into engine register writes, register reads and command launches. It also enforces the interlock: register access stalls while a command executes. One command can be queued behind the running one, and a watchdog flags a hung engine.

## Interface
- WDOG_CYCLES, 255: maximum cycles a command may stay executing before the watchdog trips (8-bit counter).
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_cpuValid  in  1  CPU operation present.
- o_cpuReady  out  1  operation accepted this cycle when high with i_cpuValid.
- i_cpuOp  in  3  E_COP2OP: 0 MTC2, 1 CTC2, 2 MFC2, 3 CFC2, 4 CMD; 5-7 reserved.
- i_cpuRegIdx  in  5  COP2 register index.
- i_cpuData  in  32  write data (MTC2/CTC2).
- i_cpuInstr  in  25  COP2 command word (CMD).
- o_cpuRdData  out  32  read result.
- o_cpuRdValid  out  1  one-cycle pulse: o_cpuRdData valid.
- o_gteRegID  out  6  engine register ID; data regs 0-31, control regs 32-63.
- o_gteWritReg  out  1  engine register write strobe.
- o_gteDataOut  out  32  engine write data.
- i_gteDataIn  in  32  engine read data, combinational from o_gteRegID.
- o_gteInstr  out  25  command word to engine.
- o_gteRun  out  1  one-cycle launch pulse.
- i_gteExecuting  in  1  engine busy; drops in the engine's last execution cycle.
- o_busy  out  1  state != IDLE or pending valid.
- o_wdogErr  out  1  sticky watchdog error.

## Operation
- States: IDLE, WRITE, READ, ISSUE, BUSY. All outputs registered.
- o_cpuReady:
  - 1 in IDLE.
  - In BUSY, 1 only if i_cpuOp==CMD and pending empty.
  - 0 in every other case.
- Reserved op accepted in IDLE: dropped, no side effect.
- IDLE, accept MTC2/CTC2 → WRITE.
  - o_gteRegID = {op==CTC2, idx}, o_gteDataOut = i_cpuData, o_gteWritReg = 1 for one cycle.
  - → IDLE.
- IDLE, accept MFC2/CFC2 → READ.
  - o_gteRegID driven; i_gteDataIn captured at end of READ.
  - → IDLE, with o_cpuRdValid pulsed the following cycle.
- IDLE, accept CMD → ISSUE.
  - o_gteInstr = i_cpuInstr, o_gteRun = 1.
  - → BUSY.
- BUSY:
  - CMD accepted → stored in pending (instr only).
  - When i_gteExecuting==0 sampled: → ISSUE with pending instr (pending cleared) if pending valid, else → IDLE.
- Interlock: MTC2/CTC2/MFC2/CFC2 are never issued while in ISSUE/BUSY; the CPU holds valid until ready.
- Watchdog:
  - 8-bit counter cleared on ISSUE, incremented each BUSY cycle.
  - On reaching WDOG_CYCLES: o_wdogErr set, pending dropped, → IDLE.
  - o_wdogErr cleared only by i_rst.
- o_gteInstr holds its last value outside ISSUE.
- o_gteRegID/o_gteDataOut hold their last value.

## Timing
- Reset (i_rst high at an edge): state IDLE, pending empty, watchdog 0, o_wdogErr 0. All outputs 0: o_gteRun, o_gteWritReg, o_cpuRdValid, o_cpuRdData, o_gteRegID, o_gteDataOut, o_gteInstr, o_busy.
- Reset mid-command: engine keeps running; sequencer forgets it. The integrator also resets the engine.
- Write accepted at edge N: o_gteWritReg high during cycle N+1; ready again in N+2.
- Read accepted at N: o_gteRegID valid in N+1; o_cpuRdValid/o_cpuRdData in N+2; ready in N+2.
- CMD accepted at N (IDLE): o_gteRun high in N+1; i_gteExecuting expected high in N+2.
- A BUSY state in which i_gteExecuting is already low in its first cycle is legal (zero-length command) and exits immediately.
- Back-to-back CMD: executing low sampled in cycle M → o_gteRun in M+1. Minimum 1 idle engine cycle.
- Simultaneous: CMD accept in BUSY in the same cycle executing drops → pending written and launched next (ISSUE at M+1 uses the just-accepted instr).
- Watchdog trip and executing drop in the same cycle: the watchdog wins.

## Structure
- Package gte_seq_pkg: E_COP2OP enum, state enum, CTRL_REG_BIT (bit 5 of regID).
- Single module; the watchdog counter is inline. No sub-module is needed.

## Test plan
- MTC2 idx 9, data 0x0000_1234 in IDLE → cycle+1 o_gteWritReg=1, o_gteRegID=9, o_gteDataOut=0x1234; ready back at +2.
- CFC2 idx 31, engine returns 0x8000_0000 → o_gteRegID=63 at +1; o_cpuRdValid with 0x8000_0000 at +2.
- CMD 0x0000001 (RTPS), executing high 14 cycles; MTC2 presented meanwhile → ready stays 0 until IDLE; write issues after.
- CMD, then second CMD 0x0000030 while BUSY → accepted, o_busy=1; on executing drop second o_gteRun next cycle with o_gteInstr=0x30.
- WDOG_CYCLES=4, executing stuck high → o_wdogErr=1 after 4 BUSY cycles, state IDLE, pending discarded; i_rst clears.
- i_rst asserted during BUSY with pending → next cycle all outputs 0, ready=1.
